jtframe_dwnld_pack: RTL
=======================

Name: jtframe_dwnld_pack

Overview:
- Next-generation ROM download adapter between the ioctl byte stream and jtframe_sdram.
- Merges byte writes into 16-bit SDRAM words, so adjacent bytes cost one SDRAM write.
- Buffers words in a parametrised FIFO, so ioctl bursts survive SDRAM stalls.
- Keeps header skip, four-bank split, byte-swap and PROM diversion; adds overflow detection and a completion pulse.

Parameters:
- HEADER, 0: number of leading ioctl bytes skipped.
- PROM_START, ~26'd0: part address where PROM region begins; all-ones means no PROM region.
- BA1_START, ~26'd0: part address where bank 1 begins; all-ones means unused.
- BA2_START, ~26'd0: part address where bank 2 begins; all-ones means unused.
- BA3_START, ~26'd0: part address where bank 3 begins; all-ones means unused.
- SWAB, 0: swap byte lanes within each word.
- FIFO_AW, 2: log2 of FIFO depth; depth = 2**FIFO_AW words, FIFO_AW >= 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- downloading  in  1  download in progress.
- ioctl_addr  in  26  byte address of the incoming byte.
- ioctl_dout  in  8  incoming byte.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- prog_addr  out  22 ([22:1])  SDRAM word address; PROM byte address in bits [21:0] during prom_we.
- prog_data  out  16  write data.
- prog_mask  out  2  byte enables, active low; bit0 selects [7:0].
- prog_we  out  1  SDRAM write request; held until ack.
- prog_ba  out  2  SDRAM bank.
- prom_we  out  1  one-cycle PROM byte write; data on prog_data[7:0].
- sdram_ack  in  1  SDRAM has accepted the current write.
- header  out  1  combinational: HEADER!=0 && ioctl_addr<HEADER && downloading.
- busy  out  1  pending word valid, FIFO non-empty, or prog_we high.
- ovf  out  1  sticky: a word was dropped on a full FIFO.
- done  out  1  one-cycle pulse when a download has fully drained.

Behaviour:
- Reset values: every output register 0, FIFO empty, pending word invalid, ovf 0. Reset mid-download discards all buffered data.
- Address decode:
  - part = ioctl_addr - HEADER, 26-bit.
  - Bank = highest k with BAk_START != all-ones and part >= BAk_START; otherwise bank 0.
  - eff = part - start of the selected bank (bank 0 start = 0).
  - lane = eff[0]^SWAB[0]. Lane 0 goes to data[15:8] with mask bit1 enabled; lane 1 goes to data[7:0] with mask bit0 enabled.
- Accepted byte: ioctl_wr && downloading && !header.
- PROM path: accepted byte with PROM_START != all-ones and part >= PROM_START.
  - Next cycle: prom_we=1 for exactly one cycle, prog_addr = part[21:0], prog_data[7:0] = byte.
  - Bypasses the FIFO. Must not disturb a held prog_we word; prog_addr and prog_data are muxed by prom_we.
- Packing register holds {word addr eff[22:1], bank, data, 2-bit valid}.
  - Byte matches pending (same word addr and bank): merge into its lane.
  - Both lanes now valid: push the word (mask 00) and clear pending the same cycle.
  - Byte does not match, or nothing pending: push the old pending word (if any) with mask = ~valid; the new byte becomes pending.
  - At most one push per cycle.
- Flush: on the cycle after downloading falls, a valid pending word is pushed with its partial mask.
- FIFO:
  - Push accepted if not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and ovf is set; ovf clears only on rst.
- Output:
  - When prog_we==0 and FIFO non-empty: pop and register addr/ba/data/mask; prog_we=1 from the next cycle.
  - prog_we stays high with stable outputs until the cycle sdram_ack==1; it is cleared on that edge.
  - Minimum one low cycle between successive words, so back-to-back throughput is one word per ack + 1 cycle.
  - Falling downloading does NOT clear prog_we; the FIFO drains after the download ends.
- done:
  - Armed by any accepted byte.
  - Fires one cycle when armed && !downloading && no pending word && FIFO empty && !prog_we; then disarms.
  - A new download re-arms it.
- Simultaneous push and pop: allowed; occupancy unchanged.
- Pointers wrap modulo depth; full/empty use an extra pointer bit.

Test Plan:
- HEADER=0, no banks; bytes 0x11@0, 0x22@1; ack 2 cycles after prog_we -> one write: prog_addr=0, prog_data=0x1122, mask=00, prog_ba=0.
- SWAB=1, same stimulus -> prog_data=0x2211, mask=00.
- Bytes 0xAA@4 then 0xBB@9, then downloading falls -> word@2 data[15:8]=AA mask=01; then word@4 data[7:0]=BB mask=10; then done pulses once.
- BA1_START=0x100, PROM_START=0x200, HEADER=0x10:
  - byte at ioctl 0x05 -> header=1, no write.
  - byte at ioctl 0x112 -> prog_ba=1, prog_addr=1.
  - byte at ioctl 0x215 -> prom_we pulse, prog_addr=0x205.
- FIFO_AW=2, sdram_ack held 0, 12 single-lane bytes at distinct words -> 4 queued, 1 held on the outputs, 1 pending; ovf=1. Release ack -> exactly 5 writes in order, then the pending word on flush.
- rst asserted while prog_we=1 with 3 words queued -> next cycle prog_we=0, busy=0, ovf=0; no further writes and no done pulse.

Source files
------------

// File: rtl/jtframe_dwnld_pack.sv
// ioctl byte stream to jtframe_sdram adapter: packs bytes into 16-bit words,
// queues them in a small FIFO and diverts the PROM region to a byte strobe.
module jtframe_dwnld_pack #(
    parameter [25:0] HEADER     = 26'd0,
    parameter [25:0] PROM_START = ~26'd0,
    parameter [25:0] BA1_START  = ~26'd0,
    parameter [25:0] BA2_START  = ~26'd0,
    parameter [25:0] BA3_START  = ~26'd0,
    parameter [0:0]  SWAB       = 1'b0,
    parameter int    FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [25:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [22:1] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic [1:0]  prog_ba,
    output logic        prom_we,
    input  logic        sdram_ack,
    output logic        header,
    output logic        busy,
    output logic        ovf,
    output logic        done
);
    localparam [25:0] NONE = ~26'd0;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int W = 42;  // {addr[21:0], ba[1:0], data[15:0], mask[1:0]}
    localparam [FIFO_AW:0] PTR_ONE = 1;

    logic [25:0] w_part;
    logic [22:0] w_start, w_eff;
    logic [1:0]  w_ba, w_bv, w_npv, w_npba;
    logic [15:0] w_bdata, w_merged, w_npdata;
    logic [21:0] w_npaddr;
    logic [W-1:0] w_pword;
    logic w_header, w_acc, w_prom, w_pack, w_lane, w_match;
    logic w_push, w_push_ok, w_pop, w_empty, w_full;

    logic [1:0]  r_pv, r_pba;
    logic [21:0] r_paddr;
    logic [15:0] r_pdata;
    logic [W-1:0] r_mem [DEPTH];
    logic [FIFO_AW:0] r_wp, r_rp;
    logic        r_we, r_prom_we, r_ovf, r_done, r_armed;
    logic [21:0] r_addr, r_prom_addr;
    logic [1:0]  r_ba, r_mask;
    logic [15:0] r_data;
    logic [7:0]  r_prom_data;

    generate
        if (HEADER != 26'd0) begin : g_hdr
            assign w_header = (ioctl_addr < HEADER) && downloading;
        end else begin : g_nohdr
            assign w_header = 1'b0;
        end
    endgenerate

    assign w_part = ioctl_addr - HEADER;

    // later checks override earlier ones, so the highest matching bank wins
    always_comb begin
        w_ba    = 2'd0;
        w_start = 23'd0;
        if (BA1_START != NONE && w_part >= BA1_START) begin w_ba = 2'd1; w_start = BA1_START[22:0]; end
        if (BA2_START != NONE && w_part >= BA2_START) begin w_ba = 2'd2; w_start = BA2_START[22:0]; end
        if (BA3_START != NONE && w_part >= BA3_START) begin w_ba = 2'd3; w_start = BA3_START[22:0]; end
    end

    assign w_eff    = w_part[22:0] - w_start;
    assign w_lane   = w_eff[0] ^ SWAB[0];
    assign w_acc    = ioctl_wr && downloading && !w_header;
    assign w_prom   = w_acc && (PROM_START != NONE) && (w_part >= PROM_START);
    assign w_pack   = w_acc && !w_prom;
    assign w_bv     = w_lane ? 2'b01 : 2'b10;
    assign w_bdata  = w_lane ? {8'h00, ioctl_dout} : {ioctl_dout, 8'h00};
    assign w_merged = w_lane ? {r_pdata[15:8], ioctl_dout} : {ioctl_dout, r_pdata[7:0]};
    assign w_match  = (r_pv != 2'b00) && (r_paddr == w_eff[22:1]) && (r_pba == w_ba);

    always_comb begin
        w_push   = 1'b0;
        w_pword  = {r_paddr, r_pba, r_pdata, ~r_pv};
        w_npv    = r_pv;
        w_npaddr = r_paddr;
        w_npba   = r_pba;
        w_npdata = r_pdata;
        if (w_pack) begin
            if (w_match) begin
                if ((r_pv | w_bv) == 2'b11) begin
                    w_push  = 1'b1;
                    w_pword = {r_paddr, r_pba, w_merged, 2'b00};
                    w_npv   = 2'b00;
                end else begin
                    w_npv    = r_pv | w_bv;
                    w_npdata = w_merged;
                end
            end else begin
                w_push   = (r_pv != 2'b00);
                w_npv    = w_bv;
                w_npaddr = w_eff[22:1];
                w_npba   = w_ba;
                w_npdata = w_bdata;
            end
        end else if (!downloading && r_pv != 2'b00) begin
            w_push = 1'b1;
            w_npv  = 2'b00;
        end
    end

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                       (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
    assign w_pop     = !r_we && !w_empty;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp[FIFO_AW-1:0]] <= w_pword;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= 2'b00; r_pba <= 2'd0; r_paddr <= '0; r_pdata <= '0;
            r_wp <= '0; r_rp <= '0;
            r_we <= 1'b0; r_addr <= '0; r_ba <= 2'd0; r_data <= '0; r_mask <= 2'b00;
            r_prom_we <= 1'b0; r_prom_addr <= '0; r_prom_data <= '0;
            r_ovf <= 1'b0; r_done <= 1'b0; r_armed <= 1'b0;
        end else begin
            r_pv    <= w_npv;
            r_paddr <= w_npaddr;
            r_pba   <= w_npba;
            r_pdata <= w_npdata;
            if (w_push_ok) r_wp <= r_wp + PTR_ONE;
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
            // a pop only happens with prog_we low, which guarantees the idle cycle between words
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
                {r_addr, r_ba, r_data, r_mask} <= r_mem[r_rp[FIFO_AW-1:0]];
                r_we <= 1'b1;
            end else if (r_we && sdram_ack) begin
                r_we <= 1'b0;
            end
            r_prom_we <= w_prom;
            if (w_prom) begin
                r_prom_addr <= w_part[21:0];
                r_prom_data <= ioctl_dout;
            end
            r_done <= 1'b0;
            if (w_acc) r_armed <= 1'b1;
            if (r_armed && !downloading && r_pv == 2'b00 && w_empty && !r_we) begin
                r_done  <= 1'b1;
                r_armed <= 1'b0;
            end
        end
    end

    assign prog_we   = r_we;
    assign prog_ba   = r_ba;
    assign prog_mask = r_mask;
    assign prom_we   = r_prom_we;
    assign prog_addr = r_prom_we ? r_prom_addr : r_addr;
    assign prog_data = r_prom_we ? {8'h00, r_prom_data} : r_data;
    assign header    = w_header;
    assign busy      = (r_pv != 2'b00) || !w_empty || r_we;
    assign ovf       = r_ovf;
    assign done      = r_done;
endmodule
